// File: rtl/cpu16_pkg.sv
// cpu16_pkg: shared funct codes, ALU select codes, control bundle and FSM states
package cpu16_pkg;
  typedef enum logic [2:0] {
    FN_AND = 3'd0,
    FN_OR  = 3'd1,
    FN_XOR = 3'd2,
    FN_ADD = 3'd3,
    FN_SUB = 3'd4,
    FN_SLT = 3'd5,
    FN_MUL = 3'd6,
    FN_ILL = 3'd7
  } funct_e;
  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_SLT = 3'b001;
  localparam logic [2:0] ALUOP_OR  = 3'b010;
  localparam logic [2:0] ALUOP_XOR = 3'b011;
  localparam logic [2:0] ALUOP_SUM = 3'b100;
  typedef struct packed {
    logic [2:0] op;
    logic       binv;
    logic       cin;
  } alu_ctrl_t;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;
endpackage

// File: rtl/alu_control_seq_decode.sv
// alu_ctrl_decode: maps a funct code to the ALU mux select, B-invert and carry-in lines
module alu_ctrl_decode
  import cpu16_pkg::*;
(
  input  logic [2:0] funct_i,
  output alu_ctrl_t  ctrl_o
);
  // SUB and SLT both subtract (invert B, carry in 1); SLT then selects the Less line
  always_comb begin
    ctrl_o.op   = (funct_i == FN_OR)  ? ALUOP_OR  :
                  (funct_i == FN_XOR) ? ALUOP_XOR :
                  (funct_i == FN_ADD || funct_i == FN_SUB) ? ALUOP_SUM :
                  (funct_i == FN_SLT) ? ALUOP_SLT : ALUOP_AND;
    ctrl_o.binv = (funct_i == FN_SUB) || (funct_i == FN_SLT);
    ctrl_o.cin  = (funct_i == FN_SUB) || (funct_i == FN_SLT);
  end
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: sequences single-pass ALU ops and a 16-pass shift-add multiply
module alu_control_seq
  import cpu16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [2:0]       AluOp,
  output logic             BInvert,
  output logic             CIN0,
  input  logic [WIDTH-1:0] AluResult,
  input  logic             AluCarryOut,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Carry,
  output logic             Negative,
  output logic             Overflow,
  output logic             Error
);
  localparam int MSB = WIDTH - 1;
  state_e           state_q;
  logic [2:0]       funct_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q, carry_q, neg_q, ovf_q, err_q, busy_q, done_q;
  alu_ctrl_t        dec;
  logic [WIDTH-1:0] mul_addend;
  logic             ovf_add, ovf_sub, is_arith;
  alu_ctrl_decode u_dec (
    .funct_i(funct_q),
    .ctrl_o (dec)
  );
  // drive the ALU: decoded controls in EXEC, forced ADD of partial product in MUL, idle otherwise
  always_comb begin
    mul_addend = b_q[cnt_q] ? (a_q << cnt_q) : '0;
    AluA       = (state_q == ST_EXEC) ? a_q : (state_q == ST_MUL) ? p_q : '0;
    AluB       = (state_q == ST_EXEC) ? b_q : (state_q == ST_MUL) ? mul_addend : '0;
    AluOp      = (state_q == ST_EXEC) ? dec.op : (state_q == ST_MUL) ? ALUOP_SUM : ALUOP_AND;
    BInvert    = (state_q == ST_EXEC) && dec.binv;
    CIN0       = (state_q == ST_EXEC) && dec.cin;
    ovf_add    = (a_q[MSB] == b_q[MSB]) && (AluResult[MSB] != a_q[MSB]);
    ovf_sub    = (a_q[MSB] != b_q[MSB]) && (AluResult[MSB] != a_q[MSB]);
    is_arith   = (funct_q == FN_ADD) || (funct_q == FN_SUB);
  end
  // control FSM: accept in IDLE, one EXEC pass or sixteen MUL passes, one-cycle DONE
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      funct_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            a_q     <= A;
            b_q     <= B;
            funct_q <= Funct;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            if (Funct == FN_ILL) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
              result_q <= '0;
              zero_q   <= 1'b1;
              carry_q  <= 1'b0;
              neg_q    <= 1'b0;
              ovf_q    <= 1'b0;
            end else if (Funct == FN_MUL) begin
              state_q <= ST_MUL;
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          result_q <= AluResult;
          zero_q   <= (AluResult == '0);
          neg_q    <= AluResult[MSB];
          carry_q  <= is_arith && AluCarryOut;
          ovf_q    <= (funct_q == FN_ADD) ? ovf_add : (funct_q == FN_SUB) ? ovf_sub : 1'b0;
          err_q    <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= ST_DONE;
        end
        ST_MUL: begin
          p_q   <= AluResult;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            result_q <= AluResult;
            zero_q   <= (AluResult == '0);
            neg_q    <= AluResult[MSB];
            carry_q  <= AluCarryOut;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign Zero     = zero_q;
  assign Carry    = carry_q;
  assign Negative = neg_q;
  assign Overflow = ovf_q;
  assign Error    = err_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: randomized scoreboard bench with a behavioural ALU and reference model
module tb_alu_control_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct = '0;
  logic [15:0] a = '0, b = '0;
  logic [15:0] alu_a, alu_b, alu_res, result;
  logic [2:0]  alu_op;
  logic        binv, cin0, alu_co, busy, done, zero, carry, neg, ovf, err;
  int checks = 0;
  int errors = 0;
  int brun = 0;
  typedef struct {
    logic [15:0] res;
    logic z, c, n, v, e;
    int   lat;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  alu_control_seq dut (
    .Clock(clk), .Reset(rst), .Start(start), .Funct(funct), .A(a), .B(b),
    .AluA(alu_a), .AluB(alu_b), .AluOp(alu_op), .BInvert(binv), .CIN0(cin0),
    .AluResult(alu_res), .AluCarryOut(alu_co), .Busy(busy), .Done(done),
    .Result(result), .Zero(zero), .Carry(carry), .Negative(neg),
    .Overflow(ovf), .Error(err)
  );
  // stand-in for the bit-slice ALU
  logic [15:0] bb;
  logic [16:0] s;
  logic        aov, less;
  always_comb begin
    bb      = binv ? ~alu_b : alu_b;
    s       = {1'b0, alu_a} + {1'b0, bb} + {16'b0, cin0};
    aov     = (alu_a[15] == bb[15]) && (s[15] != alu_a[15]);
    less    = s[15] ^ aov;
    alu_res = alu_op == 3'b000 ? (alu_a & bb) : alu_op == 3'b010 ? (alu_a | bb) :
              alu_op == 3'b011 ? (alu_a ^ bb) : alu_op == 3'b001 ? {15'b0, less} : s[15:0];
    alu_co  = s[16];
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t ref_model(int f, logic [15:0] x, logic [15:0] y);
    exp_t r;
    int sx, sy, sr;
    longint unsigned p0, ad;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.lat = 2;
    case (f)
      0: r.res = x & y;
      1: r.res = x | y;
      2: r.res = x ^ y;
      3: begin
        r.res = x + y;
        r.c = (32'(x) + 32'(y)) > 32'hFFFF;
        sr = sx + sy;
        r.v = sr > 32767 || sr < -32768;
      end
      4: begin
        r.res = x - y;
        r.c = x >= y;
        sr = sx - sy;
        r.v = sr > 32767 || sr < -32768;
      end
      5: r.res = (sx < sy) ? 16'd1 : 16'd0;
      6: begin
        r.res = 16'(longint'(x) * longint'(y));
        p0 = (longint'(x) * longint'(y & 16'h7FFF)) & 64'hFFFF;
        ad = y[15] ? ((longint'(x) << 15) & 64'hFFFF) : 64'd0;
        r.c = ((p0 + ad) >> 16) != 0;
        r.lat = 17;
      end
      default: begin
        r.res = '0;
        r.e = 1'b1;
        r.lat = 1;
      end
    endcase
    r.z = (r.res == 0);
    r.n = r.res[15];
    return r;
  endfunction
  // monitor: Busy run length gives the latency, every Done pops one expectation
  initial forever begin
    @(posedge clk);
    #1;
    if (busy) brun++;
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("zero", zero, e.z);
        chk("carry", carry, e.c);
        chk("negative", neg, e.n);
        chk("overflow", ovf, e.v);
        chk("error", err, e.e);
        chk("latency", brun, e.lat);
      end
    end
    if (!busy) brun = 0;
  end
  task automatic check_idle(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_flags"}, {zero, carry, neg, ovf, err}, 0);
    chk({tag, "_alua"}, alu_a, 0);
    chk({tag, "_alub"}, alu_b, 0);
    chk({tag, "_ctrl"}, {alu_op, binv, cin0}, 0);
  endtask
  // called at posedge+2; returns at posedge+2 after the accepting edge
  task automatic issue(int f, logic [15:0] x, logic [15:0] y);
    int n = 0;
    logic [2:0] op_tab [8] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b100, 3'b001, 3'b100, 3'b000};
    logic [1:0] inv_tab [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
    while (busy && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_wait", busy, 0);
    start = 1'b1;
    funct = 3'(f);
    a = x;
    b = y;
    q.push_back(ref_model(f, x, y));
    @(posedge clk);
    #1;
    chk("ctrl", {alu_op, binv, cin0}, {op_tab[f], inv_tab[f]});
    chk("alua", alu_a, f < 6 ? x : 16'd0);
    chk("alub", alu_b, f < 6 ? y : (f == 6 && y[0]) ? x : 16'd0);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      if (done) break;
      n++;
    end
    chk("wait_done", done, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    #1;
    rst = 1'b0;
    issue(3, 16'h7FFF, 16'h0001);
    issue(4, 16'h0005, 16'h0005);
    issue(5, 16'hFFFE, 16'h0001);
    issue(0, 16'hF0F0, 16'h0FF0);
    issue(1, 16'hF0F0, 16'h0FF0);
    issue(2, 16'hF0F0, 16'h0FF0);
    issue(6, 16'h0123, 16'h0045);
    issue(6, 16'hFFFF, 16'hFFFF);
    issue(7, 16'h1234, 16'h5678);
    issue(4, 16'h8000, 16'h0001);
    issue(5, 16'h8000, 16'h7FFF);
    // Start pulsed mid-MUL and again during the Done cycle must both be dropped
    issue(6, 16'h0101, 16'h8003);
    repeat (5) @(posedge clk);
    #2;
    start = 1'b1;
    funct = 3'd3;
    a = 16'h1111;
    b = 16'h2222;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    repeat (3) @(posedge clk);
    #2;
    // reset while the multiply counter sits at 7
    issue(6, 16'h00FF, 16'h0F0F);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check_idle("abort");
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    issue(3, 16'h1234, 16'h4321);
    for (int i = 0; i < 40; i++) begin
      int f;
      logic [15:0] x, y;
      f = $urandom_range(0, 7);
      x = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      y = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
      issue(f, x, y);
    end
    begin
      int n = 0;
      while (q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      chk("drain", q.size(), 0);
    end
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
